// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Converts core load/store requests (byte/half/word, signed/unsigned, any
//   byte address) into word-addressed BRAM beats with byte enables. It also
//   shifts store data into byte lanes, and extracts and sign-extends load data.
//
//   Build option MEM_MISALIGNED_SPLIT_EN:
//     defined   - an access that crosses a word boundary is split into two beats
//                 (lo word, then lo word + 1, wrapping).
//     undefined - a crossing access does no BRAM access. It completes at once
//                 with o_rdata = 0 and a pulse on o_misaligned.
//
// Ports
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_req_valid / o_req_ready      core request handshake (ready only in IDLE)
//   i_addr, i_wr, i_size,          byte address, store flag, size (0/1/2, 3=word),
//   i_unsigned, i_wdata            zero-extend flag, LSB-aligned store data
//   o_resp_valid, o_rdata          one-cycle completion pulse, load result
//   o_misaligned                   (split disabled only) crossing access rejected
//   o_mem_addr/data/byte_en        BRAM word address, write data, byte enables
//   o_mem_wr_valid/i_mem_wr_ready  BRAM write handshake
//   o_mem_rd_ready                 BRAM read request (one cycle per beat)
//   i_mem_data/i_mem_rd_valid      BRAM read return
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [31:0]           i_addr,
  input  logic                  i_wr,
  input  logic [1:0]            i_size,
  input  logic                  i_unsigned,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_resp_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
`ifndef MEM_MISALIGNED_SPLIT_EN
  output logic                  o_misaligned,
`endif
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [3:0]            o_mem_byte_en,
  output logic                  o_mem_wr_valid,
  input  logic                  i_mem_wr_ready,
  output logic                  o_mem_rd_ready,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_rd_valid
);

`ifdef MEM_MISALIGNED_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif
  localparam int unsigned BAW = ADDR_WIDTH + 2;

  typedef enum logic [2:0] {S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR, S_RESP} state_e;
  typedef enum logic {BEAT_LO = 1'b0, BEAT_HI = 1'b1} beat_e;

  state_e                state_q, state_d;
  beat_e                 beat_q, beat_d;
  logic [BAW-1:0]        addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [1:0]            size_q, size_d;
  logic                  uns_q, uns_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           lo_q, lo_d;

  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic [3:0]            byte_en_q, byte_en_d;
  logic                  wr_valid_q, wr_valid_d;
  logic                  rd_ready_q, rd_ready_d;
`ifndef MEM_MISALIGNED_SPLIT_EN
  logic                  misaligned_q, misaligned_d;
`endif

  // Upper byte-address bits lie outside the BRAM and are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_addr[31:BAW];

  logic                  accept_c;
  logic                  idle_c;
  logic [BAW-1:0]        cur_addr_c;
  logic [1:0]            cur_size_c;
  logic                  cur_uns_c;
  logic [31:0]           cur_wdata_c;
  logic [1:0]            off_c;
  logic [ADDR_WIDTH-1:0] lo_word_c, hi_word_c;
  logic [3:0]            mask_c, lo_en_c, hi_en_c;
  logic [7:0]            lanes_c;
  logic                  split_c;
  logic [31:0]           st_lo_c, st_hi_c;
  logic [31:0]           ld_lo_c, ld_raw_c, ld_res_c;
  logic [23:0]           ld_hi_c;

  assign accept_c = i_req_valid & req_ready_q;
  assign idle_c   = (state_q == S_IDLE);

  // In IDLE the request is derived from the live inputs so the first beat can
  // be registered on the accept edge; afterwards from the captured copy.
  assign cur_addr_c  = idle_c ? i_addr[BAW-1:0] : addr_q;
  assign cur_size_c  = idle_c ? i_size          : size_q;
  assign cur_uns_c   = idle_c ? i_unsigned      : uns_q;
  assign cur_wdata_c = idle_c ? i_wdata         : wdata_q;

  assign off_c     = cur_addr_c[1:0];
  assign lo_word_c = cur_addr_c[BAW-1:2];
  assign hi_word_c = lo_word_c + ADDR_WIDTH'(1);

  // Byte-lane enables and store data for both beats.
  always_comb begin
    case (cur_size_c)
      2'd0:    mask_c = 4'h1;
      2'd1:    mask_c = 4'h3;
      default: mask_c = 4'hF;
    endcase
    lanes_c = 8'(mask_c) << off_c;
    lo_en_c = lanes_c[3:0];
    hi_en_c = lanes_c[7:4];
    split_c = |hi_en_c;
    st_lo_c = cur_wdata_c << {off_c, 3'b000};
    case (off_c)
      2'd1:    st_hi_c = {24'd0, cur_wdata_c[31:24]};
      2'd2:    st_hi_c = {16'd0, cur_wdata_c[31:16]};
      2'd3:    st_hi_c = {8'd0,  cur_wdata_c[31:8]};
      default: st_hi_c = 32'd0;
    endcase
  end

  // Load result from the returning beat (and the saved lo word on a HI beat).
  always_comb begin
    ld_lo_c = (beat_q == BEAT_HI) ? lo_q : i_mem_data;
    ld_hi_c = (beat_q == BEAT_HI) ? i_mem_data[23:0] : 24'd0;
    case (off_c)
      2'd1:    ld_raw_c = {ld_hi_c[7:0],  ld_lo_c[31:8]};
      2'd2:    ld_raw_c = {ld_hi_c[15:0], ld_lo_c[31:16]};
      2'd3:    ld_raw_c = {ld_hi_c[23:0], ld_lo_c[31:24]};
      default: ld_raw_c = ld_lo_c;
    endcase
    case (cur_size_c)
      2'd0:    ld_res_c = {{24{~cur_uns_c & ld_raw_c[7]}},  ld_raw_c[7:0]};
      2'd1:    ld_res_c = {{16{~cur_uns_c & ld_raw_c[15]}}, ld_raw_c[15:0]};
      default: ld_res_c = ld_raw_c;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    wr_d         = wr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wdata_d      = wdata_q;
    lo_d         = lo_q;
    req_ready_d  = 1'b0;
    resp_valid_d = 1'b0;
    rdata_d      = 32'd0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = 32'd0;
    byte_en_d    = 4'd0;
    wr_valid_d   = 1'b0;
    rd_ready_d   = 1'b0;
`ifndef MEM_MISALIGNED_SPLIT_EN
    misaligned_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          req_ready_d = 1'b0;
          addr_d      = i_addr[BAW-1:0];
          wr_d        = i_wr;
          size_d      = i_size;
          uns_d       = i_unsigned;
          wdata_d     = i_wdata;
          beat_d      = BEAT_LO;
          if (split_c && !SplitEn) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
`ifndef MEM_MISALIGNED_SPLIT_EN
            misaligned_d = 1'b1;
`endif
          end else if (i_wr) begin
            state_d    = S_WR;
            wr_valid_d = 1'b1;
            mem_addr_d = lo_word_c;
            mem_data_d = st_lo_c;
            byte_en_d  = lo_en_c;
          end else begin
            state_d    = S_RD_REQ;
            rd_ready_d = 1'b1;
            mem_addr_d = lo_word_c;
          end
        end
      end
      S_RD_REQ: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (i_mem_rd_valid) begin
          if (beat_q == BEAT_LO && split_c && SplitEn) begin
            lo_d       = i_mem_data;
            beat_d     = BEAT_HI;
            state_d    = S_RD_REQ;
            rd_ready_d = 1'b1;
            mem_addr_d = hi_word_c;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            rdata_d      = ld_res_c;
          end
        end
      end
      S_WR: begin
        wr_valid_d = 1'b1;
        mem_data_d = mem_data_q;
        byte_en_d  = byte_en_q;
        if (i_mem_wr_ready) begin
          if (beat_q == BEAT_LO && split_c && SplitEn) begin
            beat_d     = BEAT_HI;
            mem_addr_d = hi_word_c;
            mem_data_d = st_hi_c;
            byte_en_d  = hi_en_c;
          end else begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            wr_valid_d   = 1'b0;
            mem_data_d   = 32'd0;
            byte_en_d    = 4'd0;
          end
        end
      end
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      beat_q       <= BEAT_LO;
      addr_q       <= '0;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      wdata_q      <= 32'd0;
      lo_q         <= 32'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'd0;
      mem_addr_q   <= '0;
      mem_data_q   <= 32'd0;
      byte_en_q    <= 4'd0;
      wr_valid_q   <= 1'b0;
      rd_ready_q   <= 1'b0;
`ifndef MEM_MISALIGNED_SPLIT_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wdata_q      <= wdata_d;
      lo_q         <= lo_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      byte_en_q    <= byte_en_d;
      wr_valid_q   <= wr_valid_d;
      rd_ready_q   <= rd_ready_d;
`ifndef MEM_MISALIGNED_SPLIT_EN
      misaligned_q <= misaligned_d;
`endif
    end
  end

  // The captured store flag only steers the FSM at accept time.
  logic unused_wr_q;
  assign unused_wr_q = wr_q;

  assign o_req_ready    = req_ready_q;
  assign o_resp_valid   = resp_valid_q;
  assign o_rdata        = rdata_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_data     = mem_data_q;
  assign o_mem_byte_en  = byte_en_q;
  assign o_mem_wr_valid = wr_valid_q;
  assign o_mem_rd_ready = rd_ready_q;
`ifndef MEM_MISALIGNED_SPLIT_EN
  assign o_misaligned   = misaligned_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed requests against a small BRAM model.
// Expected responses and BRAM beats are queued when stimulus is issued; a
// negedge monitor pops and compares them whenever the DUT presents them.
module tb_mem_access_unit;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   addr = '0;
  logic          wr = 1'b0;
  logic [1:0]    size = '0;
  logic          uns = 1'b0;
  logic [31:0]   wdata = '0;
  logic          resp_valid;
  logic [31:0]   rdata;
  logic          mis;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic          mem_rd_ready;
  logic [31:0]   mem_rdata;
  logic          mem_rd_valid;

  // BRAM model controls
  logic          stall_rd = 1'b0;
  logic          force_rd = 1'b0;
  logic          force_wr = 1'b0;
  logic          rd_valid_m = 1'b0;
  logic [31:0]   rd_data_m = '0;
  logic [31:0]   mem [0:1023];

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_addr(addr), .i_wr(wr), .i_size(size), .i_unsigned(uns), .i_wdata(wdata),
    .o_resp_valid(resp_valid), .o_rdata(rdata),
`ifndef MEM_MISALIGNED_SPLIT_EN
    .o_misaligned(mis),
`endif
    .o_mem_addr(mem_addr), .o_mem_data(mem_wdata), .o_mem_byte_en(mem_be),
    .o_mem_wr_valid(mem_wr_valid), .i_mem_wr_ready(mem_wr_ready),
    .o_mem_rd_ready(mem_rd_ready), .i_mem_data(mem_rdata),
    .i_mem_rd_valid(mem_rd_valid)
  );

`ifdef MEM_MISALIGNED_SPLIT_EN
  assign mis = 1'b0;
`endif

  // BRAM: combinational write accept, one-cycle read latency.
  assign mem_wr_ready = mem_wr_valid | force_wr;
  assign mem_rd_valid = rd_valid_m | force_rd;
  assign mem_rdata    = rd_data_m;
  always @(posedge clk) begin
    rd_valid_m <= mem_rd_ready && !stall_rd;
    rd_data_m  <= mem[mem_addr];
    if (mem_wr_valid && mem_wr_ready)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  typedef struct { logic [31:0] rdata; logic mis; int t0; int lat; } resp_t;
  typedef struct { logic [AW-1:0] addr; logic [31:0] data; logic [3:0] be; } wbeat_t;

  resp_t         resp_q[$];
  wbeat_t        wr_q[$];
  logic [AW-1:0] rd_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  always @(negedge clk) begin
    resp_t e;
    wbeat_t w;
    logic [AW-1:0] ra;
    if (resp_valid) begin
      vectors++;
      if (resp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected: got rdata=%h mis=%b, none expected", rdata, mis);
      end else begin
        e = resp_q.pop_front();
        if (rdata !== e.rdata || mis !== e.mis || cyc + 1 != e.t0 + e.lat) begin
          miscompares++;
          $display("FAIL resp: got rdata=%h mis=%b at T0+%0d, want rdata=%h mis=%b at T0+%0d",
                   rdata, mis, cyc + 1 - e.t0, e.rdata, e.mis, e.lat);
        end
      end
    end
    if (mis && !resp_valid) begin
      vectors++; miscompares++;
      $display("FAIL misaligned_stray: got 1 without resp_valid, want 0");
    end
    if (mem_wr_valid && mem_rd_ready) begin
      vectors++; miscompares++;
      $display("FAIL rd_wr_overlap: got wr_valid=1 rd_ready=1, want exclusive");
    end
    if (mem_wr_valid && mem_wr_ready) begin
      vectors++;
      if (wr_q.size() == 0) begin
        miscompares++;
        $display("FAIL wr_beat_unexpected: got addr=%h data=%h be=%h", mem_addr, mem_wdata, mem_be);
      end else begin
        w = wr_q.pop_front();
        if (mem_addr !== w.addr || mem_wdata !== w.data || mem_be !== w.be) begin
          miscompares++;
          $display("FAIL wr_beat: got addr=%h data=%h be=%h, want addr=%h data=%h be=%h",
                   mem_addr, mem_wdata, mem_be, w.addr, w.data, w.be);
        end
      end
    end
    if (mem_rd_ready) begin
      vectors++;
      if (rd_q.size() == 0) begin
        miscompares++;
        $display("FAIL rd_beat_unexpected: got addr=%h", mem_addr);
      end else begin
        ra = rd_q.pop_front();
        if (mem_addr !== ra) begin
          miscompares++;
          $display("FAIL rd_beat: got addr=%h, want addr=%h", mem_addr, ra);
        end
      end
    end
  end

  task automatic exp_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    wbeat_t w;
    w.addr = a; w.data = d; w.be = be;
    wr_q.push_back(w);
  endtask

  task automatic exp_rd(input logic [AW-1:0] a);
    rd_q.push_back(a);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      vectors++; miscompares++;
      $display("FAIL req_ready_timeout: got %b, want 1", req_ready);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic em, input int lat);
    resp_t e;
    int n;
    wait_ready();
    req_valid = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = wd;
    @(posedge clk); #1;
    e.rdata = er; e.mis = em; e.t0 = cyc; e.lat = lat;
    resp_q.push_back(e);
    @(negedge clk);
    // Changing inputs after accept must not matter.
    req_valid = 1'b0; wr = ~w; size = ~sz; uns = ~u; addr = ~a; wdata = ~wd;
    n = 0;
    while (resp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
    if (resp_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL resp_timeout: got %0d pending responses, want 0", resp_q.size());
      resp_q.delete();
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    vectors++;
    if ({req_ready, resp_valid, rdata, mem_addr, mem_wdata, mem_be, mem_wr_valid, mem_rd_ready, mis} !== '0) begin
      miscompares++;
      $display("FAIL %s: got ready=%b resp=%b rdata=%h addr=%h data=%h be=%h wv=%b rr=%b mis=%b, want all 0",
               nm, req_ready, resp_valid, rdata, mem_addr, mem_wdata, mem_be, mem_wr_valid, mem_rd_ready, mis);
    end
  endtask

  task automatic chk_ready(input string nm);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: got req_ready=%b, want 1", nm, req_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2 chk_outputs_zero("reset_outputs");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_ready("ready_after_reset");

    // Aligned word store and load
    exp_wr(10'h040, 32'h11223344, 4'hF);
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h11223344, 32'h0, 1'b0, 2);
    exp_rd(10'h040);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h11223344, 1'b0, 3);

    // Sub-word stores and loads
    exp_wr(10'h040, 32'h00000031, 4'h1);
    do_req(1'b1, 2'd0, 1'b0, 32'h100, 32'h31, 32'h0, 1'b0, 2);
    exp_wr(10'h040, 32'h00003200, 4'h2);
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h32, 32'h0, 1'b0, 2);
    exp_wr(10'h040, 32'h34330000, 4'hC);
    do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h3433, 32'h0, 1'b0, 2);
    exp_rd(10'h040);
    do_req(1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'h00000033, 1'b0, 3);
    exp_rd(10'h040);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h00000034, 1'b0, 3);
    exp_rd(10'h040);
    do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 32'h00003231, 1'b0, 3);

    // Sign extension; size 3 behaves as word
    exp_wr(10'h040, 32'h80008001, 4'hF);
    do_req(1'b1, 2'd3, 1'b0, 32'h100, 32'h80008001, 32'h0, 1'b0, 2);
    exp_rd(10'h040);
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    exp_rd(10'h040);
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 3);
    exp_rd(10'h040);
    do_req(1'b0, 2'd1, 1'b0, 32'h100, 32'h0, 32'hFFFF8001, 1'b0, 3);
    exp_rd(10'h040);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hFFFF8000, 1'b0, 3);
    exp_rd(10'h040);
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 32'h80008001, 1'b0, 3);

    // Word-crossing accesses
`ifdef MEM_MISALIGNED_SPLIT_EN
    exp_wr(10'h040, 32'hCCDD0000, 4'hC);
    exp_wr(10'h041, 32'h0000AABB, 4'h3);
    do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'hAABBCCDD, 32'h0, 1'b0, 3);
    exp_rd(10'h040); exp_rd(10'h041);
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hAABBCCDD, 1'b0, 5);
    exp_rd(10'h040);
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h0000CCDD, 1'b0, 3);
    exp_wr(10'h040, 32'hEF000000, 4'h8);
    exp_wr(10'h041, 32'h000000BE, 4'h1);
    do_req(1'b1, 2'd1, 1'b0, 32'h103, 32'hBEEF, 32'h0, 1'b0, 3);
    exp_rd(10'h040); exp_rd(10'h041);
    do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'hFFFFBEEF, 1'b0, 5);
`else
    do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'hAABBCCDD, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1);
    exp_rd(10'h040);
    do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'h0, 32'h00008000, 1'b0, 3);
    do_req(1'b1, 2'd1, 1'b0, 32'h103, 32'hBEEF, 32'h0, 1'b1, 1);
    do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'h0, 32'h0, 1'b1, 1);
`endif

    // Address wrap at the top of the BRAM
    exp_wr(10'h3FF, 32'h55667788, 4'hF);
    do_req(1'b1, 2'd2, 1'b0, 32'hFFC, 32'h55667788, 32'h0, 1'b0, 2);
    exp_wr(10'h000, 32'h99AABBCC, 4'hF);
    do_req(1'b1, 2'd2, 1'b0, 32'h000, 32'h99AABBCC, 32'h0, 1'b0, 2);
    exp_rd(10'h3FF);
    do_req(1'b0, 2'd1, 1'b1, 32'hFFE, 32'h0, 32'h00005566, 1'b0, 3);
`ifdef MEM_MISALIGNED_SPLIT_EN
    exp_rd(10'h3FF); exp_rd(10'h000);
    do_req(1'b0, 2'd2, 1'b0, 32'hFFE, 32'h0, 32'hBBCC5566, 1'b0, 5);
`else
    do_req(1'b0, 2'd2, 1'b0, 32'hFFE, 32'h0, 32'h0, 1'b1, 1);
`endif

    // Reset while waiting for read data: the load is dropped silently
    stall_rd = 1'b1;
    exp_rd(10'h040);
    wait_ready();
    req_valid = 1'b1; wr = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h100;
    @(posedge clk); #1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_outputs_zero("reset_mid_rd_wait");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_ready("ready_after_mid_reset");
    // Late read data and a stray write accept while IDLE are ignored.
    force_rd = 1'b1; force_wr = 1'b1; stall_rd = 1'b0;
    @(negedge clk);
    force_rd = 1'b0; force_wr = 1'b0;
    repeat (6) @(negedge clk);
    chk_ready("ready_idle_after_stray");

    vectors++;
    if (resp_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) begin
      miscompares++;
      $display("FAIL queues_drained: got resp=%0d wr=%0d rd=%0d pending, want 0",
               resp_q.size(), wr_q.size(), rd_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly upstream of the ready/valid BRAM wrapper: converts core load/store requests (byte/half/word, signed/unsigned, any byte address) into word-addressed BRAM transactions with byte enables.
- Performs store-data lane shifting, load-data extraction and sign extension.
- Splits word-crossing accesses into two BRAM beats.

Parameters:
ADDR_WIDTH, 10, BRAM word-address width; byte address bits [ADDR_WIDTH+1:2] select the word
DATA_WIDTH, 32, word width; fixed at 32

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous assert, active-low
i_req_valid  in  1  core request valid
o_req_ready  out  1  unit can accept a request (high only in IDLE)
i_addr  in  32  byte address
i_wr  in  1  1 = store, 0 = load
i_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
i_unsigned  in  1  load zero-extends when set, sign-extends otherwise
i_wdata  in  32  store data, LSB-aligned
o_resp_valid  out  1  one-cycle completion pulse (loads and stores)
o_rdata  out  32  load result; valid with o_resp_valid, 0 otherwise
o_mem_addr  out  ADDR_WIDTH  BRAM word address
o_mem_data  out  32  BRAM write data
o_mem_byte_en  out  4  BRAM byte write enables
o_mem_wr_valid  out  1  BRAM write request
i_mem_wr_ready  in  1  BRAM write accept (may be combinational on wr_valid)
o_mem_rd_ready  out  1  BRAM read request
i_mem_data  in  32  BRAM read data
i_mem_rd_valid  in  1  BRAM read data valid

Behaviour:
- Reset:
  - State returns to IDLE immediately.
  - All outputs are 0, except o_req_ready, which is 1 after reset release.
  - Any in-flight beat is dropped and no response is issued.
- Accept: the request is captured when i_req_valid && o_req_ready at a rising edge. Captured fields: addr, wr, size, unsigned, wdata.
- Derived values (o = addr[1:0]; mask = 1/3/F for byte/half/word):
  - Lane vector ext = mask << o (8 bits).
  - lo enables = ext[3:0]; hi enables = ext[7:4]. Split is needed iff hi enables != 0.
  - lo word = addr[ADDR_WIDTH+1:2]; hi word = lo word + 1, wrapping modulo 2^ADDR_WIDTH.
  - Store data: lo beat = (wdata << 8*o)[31:0]; hi beat = wdata >> (32 - 8*o).
- FSM states: IDLE, RD_REQ, RD_WAIT, WR, RESP. A beat flag (LO/HI) is held alongside the state.
  - IDLE: o_req_ready=1. On accept, go to WR if store, RD_REQ if load; beat=LO.
  - RD_REQ: o_mem_rd_ready=1 for exactly one cycle with o_mem_addr = current beat word; go to RD_WAIT.
  - RD_WAIT: o_mem_addr is held. On i_mem_rd_valid, capture i_mem_data into lo_q or hi_q.
    - If LO and split: beat=HI, go to RD_REQ.
    - Otherwise: go to RESP.
  - WR: drive o_mem_wr_valid=1, o_mem_addr, o_mem_data, and o_mem_byte_en for the current beat. Hold all of these until i_mem_wr_ready.
    - If LO and split: beat=HI, stay in WR.
    - Otherwise: go to RESP.
  - RESP: o_resp_valid=1 for one cycle; go to IDLE. A new request can be accepted one cycle later.
- Load result:
  - raw = ({hi_q, lo_q} >> 8*o)[31:0], with hi_q = 0 when not split.
  - Truncate raw to size.
  - Sign-extend from bit 7/15 unless unsigned. Word loads are not extended.
- Latency (accept edge = T0):
  - Aligned load: rd_ready in T0+1, rd_valid in T0+2, resp in T0+3.
  - Split load: resp in T0+5.
  - Store with combinational wr_ready: resp in T0+2 (one beat) or T0+3 (split).
- The response has no backpressure. o_mem_wr_valid and o_mem_rd_ready are never both high.
- i_mem_rd_valid outside RD_WAIT is ignored. An unexpected i_mem_wr_ready outside WR is ignored.
- Inputs changing after accept have no effect.

Optional Feature:
MEM_MISALIGNED_SPLIT_EN
- Defined: split behaviour as above.
- Undefined:
  - A request needing a split does no BRAM access.
  - The FSM goes straight to RESP and o_resp_valid pulses with o_rdata=0.
  - An extra output o_misaligned (1 bit) pulses with o_resp_valid for that request and is 0 at all other times.
  - Non-crossing accesses are unchanged.

Test Plan:
- Reset: deassert i_rst_n mid RD_WAIT -> outputs immediately 0; after release o_req_ready=1; a later rd_valid is ignored and no o_resp_valid pulse occurs.
- Aligned SW 0x11223344 to 0x100, then LW 0x100 -> write beat addr 0x40, byte_en F; load o_rdata=0x11223344 at T0+3.
- SB 0x31 @0x100, SB 0x32 @0x101, SH 0x3433 @0x102, then LBU @0x102 -> 0x33; LBU @0x103 -> 0x34; LHU @0x100 -> 0x3231; byte_en 1/2/C.
- LB @0x103 with memory byte 0x80 -> 0xFFFFFF80; LBU same address -> 0x00000080; LH @0x100 with memory half 0x8001 -> 0xFFFF8001.
- Split SW 0xAABBCCDD @0x102:
  - With the macro: beats addr 0x40 en C data 0xCCDD0000, then addr 0x41 en 3 data 0x0000AABB. LW @0x102 returns 0xAABBCCDD at T0+5.
  - Without the macro: no BRAM activity, o_misaligned=1.
- Wrap: ADDR_WIDTH=10, LW @0xFFE -> beats word 0x3FF then 0x000; result combines the upper half of word 0x3FF and the lower half of word 0x000.
